// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the systolic-array activation path.
//   - DEFAULT_SYSTOLIC_SIZE / DEFAULT_ACTIVATION_WIDTH: default array geometry.
//   - feeder_state_t: state encoding of the activation skew feeder FSM.
//   - feeder_accepts(): true in the states where a new vector may be taken.
// ----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DEFAULT_SYSTOLIC_SIZE    = 8;
    localparam int DEFAULT_ACTIVATION_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } feeder_state_t;

    // New vectors are accepted while idle or mid-tile, never while draining.
    function automatic logic feeder_accepts(input feeder_state_t s);
        return (s != ST_DRAIN);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// ----------------------------------------------------------------------------
// skew_delay_line
//   Data + valid shift register of DEPTH+1 register stages (DEPTH=0 is a
//   single register). A data stage only loads when the stage feeding it holds
//   valid data, so the output keeps the last valid value across bubbles.
//
//   Parameters: DEPTH (extra stages beyond the first), WIDTH (data bits).
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous active-high reset (clears data and valid)
//     i_valid  in   stage-0 valid
//     i_data   in   stage-0 data
//     o_valid  out  valid of the last stage
//     o_data   out  data of the last stage
// ----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data [0:DEPTH];
    logic             r_vld  [0:DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= DEPTH; k++) begin
                r_data[k] <= '0;
                r_vld[k]  <= 1'b0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int k = 1; k <= DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                // Gate the data move on valid so bubbles do not toggle data.
                if (r_vld[k-1]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign o_valid = r_vld[DEPTH];
    assign o_data  = r_data[DEPTH];

endmodule

// File: rtl/activation_skew_feeder.sv
// ----------------------------------------------------------------------------
// activation_skew_feeder
//   Accepts aligned activation vectors (valid/ready) and presents them to the
//   systolic array with lane i delayed by i extra cycles, so lane i of a
//   vector accepted at edge t is visible in the cycle after edge t+i.
//   A tile ends with an in_last transfer; the FSM then drains for
//   SYSTOLIC_SIZE cycles and pulses tile_done when the last vector leaves
//   the final lane.
//
//   Configuration macro SKEW_FEEDER_ZERO_FILL_EN:
//     defined   - invalid lanes drive zero on activation_flat
//     undefined - invalid lanes hold their last valid value
//
//   Parameters: SYSTOLIC_SIZE (lanes), ACTIVATION_WIDTH (bits per lane).
//   Ports:
//     clk             in   clock, rising edge
//     rst             in   synchronous active-high reset
//     in_valid        in   aligned vector offered
//     in_ready        out  vector accepted this cycle (state-only, low in rst)
//     in_last         in   offered vector is the last of the tile
//     act_in_flat     in   aligned vector, lane i at [i*W +: W]
//     activation_flat out  skewed vector, same packing
//     lane_valid      out  per-lane valid qualifier
//     busy            out  FSM not idle or any lane still valid
//     tile_done       out  one-cycle pulse on the final drain cycle
// ----------------------------------------------------------------------------
module activation_skew_feeder
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_SIZE    = DEFAULT_SYSTOLIC_SIZE,
    parameter int ACTIVATION_WIDTH = DEFAULT_ACTIVATION_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_last,
    input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_in_flat,
    output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] activation_flat,
    output logic [SYSTOLIC_SIZE-1:0]               lane_valid,
    output logic                                   busy,
    output logic                                   tile_done
);

    localparam int               CNT_W    = $clog2(SYSTOLIC_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SYSTOLIC_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    feeder_state_t    r_state;
    feeder_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_xfer;

    // Ready depends only on state (and reset), never on in_valid.
    assign in_ready = feeder_accepts(r_state) && !rst;
    assign w_xfer   = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        tile_done   = 1'b0;
        case (r_state)
            ST_IDLE, ST_FEED: begin
                if (w_xfer) begin
                    if (in_last) begin
                        // The last vector needs SYSTOLIC_SIZE more cycles to
                        // clear lane SYSTOLIC_SIZE-1.
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = ST_FEED;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_cnt > CNT_ONE) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    // Final drain cycle: last lane is showing the last vector.
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    tile_done   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-lane skew delay lines: lane i has i extra register stages
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < SYSTOLIC_SIZE; g++) begin : g_lane
        logic                        w_lane_vld;
        logic [ACTIVATION_WIDTH-1:0] w_lane_data;

        skew_delay_line #(
            .DEPTH (g),
            .WIDTH (ACTIVATION_WIDTH)
        ) u_delay (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_xfer),
            .i_data  (act_in_flat[g*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]),
            .o_valid (w_lane_vld),
            .o_data  (w_lane_data)
        );

        assign lane_valid[g] = w_lane_vld;
`ifdef SKEW_FEEDER_ZERO_FILL_EN
        assign activation_flat[g*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] =
            w_lane_vld ? w_lane_data : '0;
`else
        assign activation_flat[g*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] = w_lane_data;
`endif
    end

    assign busy = (r_state != ST_IDLE) || (|lane_valid);

endmodule

// File: doc/activation_skew_feeder.md
ACTIVATION_SKEW_FEEDER -- requirements
Module: activation_skew_feeder

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, number of array rows/lanes (>=1).
REQ-002 SHALL have parameter ACTIVATION_WIDTH, default 8, bits per activation.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  aligned activation vector offered.
REQ-006 SHALL have port in_ready  output  1  feeder accepts the vector this cycle.
REQ-007 SHALL have port in_last  input  1  offered vector is the last of a tile.
REQ-008 SHALL have port act_in_flat  input  SYSTOLIC_SIZE*ACTIVATION_WIDTH  aligned vector; lane i at [i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH].
REQ-009 SHALL have port activation_flat  output  SYSTOLIC_SIZE*ACTIVATION_WIDTH  skewed vector to the systolic array activation inputs, same packing.
REQ-010 SHALL have port lane_valid  output  SYSTOLIC_SIZE  bit i: lane i of activation_flat carries accepted data.
REQ-011 SHALL have port busy  output  1  state not IDLE or any lane_valid bit set.
REQ-012 SHALL have port tile_done  output  1  one-cycle pulse when the last tile vector fully leaves lane SYSTOLIC_SIZE-1.

Function
REQ-013 Transfer SHALL occur on a cycle with in_valid && in_ready; in_ready SHALL be combinational from state only, never from in_valid.
REQ-014 FSM SHALL have states IDLE, FEED, DRAIN; in_ready=1 in IDLE and FEED, 0 in DRAIN and while rst is high.
REQ-015 IDLE->FEED on transfer with in_last=0; IDLE or FEED->DRAIN on transfer with in_last=1 (single-vector tile goes IDLE->DRAIN directly).
REQ-016 FEED SHALL hold across cycles without transfer (bubbles permitted, no timeout).
REQ-017 For a vector transferred at edge t, lane i SHALL appear on activation_flat with lane_valid[i]=1 during the cycle after edge t+i (latency 1+i cycles).
REQ-018 Cycles without transfer SHALL inject a bubble: the corresponding lane slots carry lane_valid[i]=0.
REQ-019 Vector order per lane SHALL be preserved; no vector dropped or duplicated.
REQ-020 DRAIN SHALL last exactly SYSTOLIC_SIZE cycles after the last transfer via a down-counter of width $clog2(SYSTOLIC_SIZE+1), then return to IDLE.
REQ-021 tile_done SHALL be asserted in the same cycle lane SYSTOLIC_SIZE-1 presents the last vector, i.e. final DRAIN cycle.
REQ-022 Lane data SHALL pass unmodified (no arithmetic, no width change).

Reset
REQ-023 While rst is high at an edge: state<=IDLE, drain counter<=0, all delay-line data and valid bits<=0.
REQ-024 After reset: activation_flat=0, lane_valid=0, busy=0, tile_done=0, in_ready=1 from first cycle with rst low.
REQ-025 Reset mid-tile SHALL discard in-flight vectors and SHALL NOT produce tile_done.

Configuration
REQ-026 Macro SKEW_FEEDER_ZERO_FILL_EN defined: a lane with lane_valid[i]=0 SHALL drive zero on its activation_flat slice.
REQ-027 Macro undefined: an invalid lane SHALL hold its last valid value (toggle reduction); consumers qualify with lane_valid.

Structure
REQ-028 Default SYSTOLIC_SIZE and ACTIVATION_WIDTH and the FSM state encoding SHALL live in shared package systolic_pkg.
REQ-029 One sub-module skew_delay_line (parameters DEPTH, WIDTH; data+valid shift register, DEPTH=0 means a single register) SHALL be instantiated per lane with DEPTH=i.

Verification (SYSTOLIC_SIZE=4, ACTIVATION_WIDTH=8)
REQ-030 Reset then idle -> activation_flat=0, lane_valid=4'b0000, in_ready=1, busy=0.
REQ-031 Back-to-back vectors {0x03,0x02,0x01,0x00},{0x13,..,0x10},{0x23,..,0x20} (in_last on third) at edges 0..2 -> lane0 0x00/0x10/0x20 in cycles 1-3, lane3 0x03/0x13/0x23 in cycles 4-6; tile_done only in cycle 6; in_ready=0 cycles 3-6.
REQ-032 Single vector 0xAABBCCDD with in_last in IDLE -> IDLE->DRAIN; lanes 0..3 show 0xDD,0xCC,0xBB,0xAA in cycles 1..4; tile_done in cycle 4; IDLE in cycle 5.
REQ-033 Bubble: transfers at edges 0 and 2 only -> lane1 valid in cycles 2 and 4, invalid in cycle 3, slice=0 with SKEW_FEEDER_ZERO_FILL_EN, previous value without.
REQ-034 rst asserted one cycle after in_last transfer -> next cycle all outputs zero, no tile_done ever, in_ready=1 after rst low.
REQ-035 in_valid held high through DRAIN -> no transfer until IDLE; vector offered then accepted exactly once.
